// File: rtl/cmp_div_seq_if.sv
// rtl/cmp_div_seq_if.sv - request/result bundle between the EX stage and the DIVU/REMU sequencer.
interface cmp_div_seq_if #(
    parameter int XLEN = 32
);
    logic            i_start;
    logic [XLEN-1:0] i_dividend;
    logic [XLEN-1:0] i_divisor;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_quotient;
    logic [XLEN-1:0] o_remainder;
    logic            o_div_by_zero;

    modport master (
        output i_start,
        output i_dividend,
        output i_divisor,
        input  o_busy,
        input  o_done,
        input  o_quotient,
        input  o_remainder,
        input  o_div_by_zero
    );

    modport slave (
        input  i_start,
        input  i_dividend,
        input  i_divisor,
        output o_busy,
        output o_done,
        output o_quotient,
        output o_remainder,
        output o_div_by_zero
    );
endinterface

// File: rtl/cmp_div_seq.sv
// rtl/cmp_div_seq.sv - restoring unsigned divider sequencer, one compare-and-subtract per cycle.
// Optional CMP_DIV_EARLY_OUT_EN: dividend < divisor finishes in one edge.
module cmp_div_seq #(
    parameter int XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    cmp_div_seq_if.slave       bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] divisor_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] quo_reg;
    logic [CW-1:0]   count;

    logic [XLEN:0]   trial;
    logic            trial_lt;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic            last_iter;
    logic            start_ok;
    logic            early_out;

    // The partial remainder is always below the divisor, so trial < 2*divisor
    // and the difference fits back into XLEN bits.
    always_comb begin
        trial     = {rem_reg, quo_reg[XLEN-1]};
        trial_lt  = trial < {1'b0, divisor_reg};
        rem_next  = trial_lt ? trial[XLEN-1:0] : (trial[XLEN-1:0] - divisor_reg);
        quo_next  = {quo_reg[XLEN-2:0], ~trial_lt};
        last_iter = (count == CW'(XLEN - 1));
        start_ok  = bus.i_start && (state != CALC);
    end

`ifdef CMP_DIV_EARLY_OUT_EN
    assign early_out = bus.i_dividend < bus.i_divisor;
`else
    assign early_out = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            divisor_reg       <= '0;
            rem_reg           <= '0;
            quo_reg           <= '0;
            count             <= '0;
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_quotient    <= '0;
            bus.o_remainder   <= '0;
            bus.o_div_by_zero <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        divisor_reg       <= bus.i_divisor;
                        rem_reg           <= '0;
                        quo_reg           <= bus.i_dividend;
                        count             <= '0;
                        bus.o_div_by_zero <= 1'b0;
                        if (bus.i_divisor == '0) begin
                            state             <= DONE;
                            bus.o_done        <= 1'b1;
                            bus.o_busy        <= 1'b0;
                            bus.o_quotient    <= '1;
                            bus.o_remainder   <= bus.i_dividend;
                            bus.o_div_by_zero <= 1'b1;
                        end else if (early_out) begin
                            state           <= DONE;
                            bus.o_done      <= 1'b1;
                            bus.o_busy      <= 1'b0;
                            bus.o_quotient  <= '0;
                            bus.o_remainder <= bus.i_dividend;
                        end else begin
                            state      <= CALC;
                            bus.o_busy <= 1'b1;
                        end
                    end else begin
                        state      <= IDLE;
                        bus.o_busy <= 1'b0;
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    count   <= count + CW'(1);
                    if (last_iter) begin
                        state           <= DONE;
                        bus.o_busy      <= 1'b0;
                        bus.o_done      <= 1'b1;
                        bus.o_quotient  <= quo_next;
                        bus.o_remainder <= rem_next;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/cmp_div_seq.md
Name: cmp_div_seq

Overview:
- Multi-cycle unsigned divider sequencer for the M-extension DIVU/REMU path.
- Each cycle it drives one shared compare-and-subtract step: an unsigned less-than test followed by a conditional subtract. It owns the iteration counter, the shift registers and the start/done handshake.
- Sits beside the ALU in EX. The pipeline stalls on o_busy and captures results on o_done.

Parameters:
- XLEN, 32, operand/result width in bits; counter width is clog2(XLEN)+1.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  request a division; sampled only when o_busy=0
- i_dividend  input  XLEN  unsigned dividend, sampled with i_start
- i_divisor  input  XLEN  unsigned divisor, sampled with i_start
- o_busy  output  1  high while the iteration is in progress
- o_done  output  1  one-cycle pulse; results valid
- o_quotient  output  XLEN  unsigned quotient, held until next accepted start
- o_remainder  output  XLEN  unsigned remainder, held until next accepted start
- o_div_by_zero  output  1  divisor was 0 for the current result; held with results

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE; o_busy=0; o_done=0; o_quotient=0; o_remainder=0; o_div_by_zero=0; counter=0.
- Reset mid-operation: aborts immediately (asynchronously) to the reset values. No partial results survive.
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: output pulse.
- IDLE/DONE with i_start=1 at edge T0:
  - Latch divisor into a register.
  - rem_reg=0, quo_reg=dividend, counter=0, o_div_by_zero=0.
  - If divisor=0: go to DONE with quotient=all ones, remainder=dividend, o_div_by_zero=1.
  - Otherwise go to CALC.
- CALC, each edge:
  - trial = {rem_reg, quo_reg[XLEN-1]}, XLEN+1 bits wide.
  - quo shifted left 1.
  - If trial < divisor (unsigned, zero-extended divisor): rem_reg=trial[XLEN-1:0] and new quo LSB=0.
  - Else: rem_reg=trial-divisor and new quo LSB=1.
  - counter increments; on the XLEN-th iteration (counter=XLEN-1) go to DONE.
- Latency:
  - Divisor≠0: o_done=1 in the cycle after edge T0+XLEN, i.e. XLEN+1 edges after the start edge.
  - Divisor=0: o_done=1 in the cycle after T0, one edge.
- DONE:
  - o_done=1 for exactly one cycle.
  - o_quotient/o_remainder update from quo_reg/rem_reg on entry to DONE and hold afterwards.
  - Next edge goes to IDLE, or restarts if i_start=1.
- o_busy=1 exactly in CALC. i_start during CALC is ignored; no queueing.
- Operand changes while busy have no effect, because operands are latched at start.
- Result invariant: quotient*divisor+remainder=dividend, with remainder<divisor, for divisor≠0.

Optional Feature:
- Macro: CMP_DIV_EARLY_OUT_EN.
- Defined: on an accepted start with divisor≠0 and dividend<divisor (unsigned), skip CALC and go directly to DONE with quotient=0, remainder=dividend. Latency is 1 edge.
- Undefined: such operands take the full XLEN+1 edges and produce the same values.

Test Plan:
- Start 100/7 (divisor≠0, full iteration) -> o_busy high 32 cycles; o_done pulse at edge 33; q=14, r=2, o_div_by_zero=0.
- Start 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0 after 33 edges. Then 0x80000000/0xFFFFFFFF -> q=0, r=0x80000000.
- Start 1234/0 -> o_done at edge 1; q=0xFFFFFFFF, r=1234, o_div_by_zero=1; o_busy never asserted.
- Start 1000/10, then pulse i_start with 9/3 at cycle 5 -> second request ignored; result q=100, r=0; exactly one o_done pulse.
- Start 50/3, drive i_rst_n=0 at cycle 10 (between clock edges) -> outputs zero immediately. After release, start 50/3 -> q=16, r=2 after 33 edges.
- Start 5/9 -> q=0, r=5; o_done at edge 1 with CMP_DIV_EARLY_OUT_EN defined, at edge 33 without.
